mmss_time_counter: RTL and testbench
====================================

Name: mmss_time_counter

Overview:
- Real-time MM:SS counter directly downstream of the switch-to-BCD initial-time stage.
- Loads four BCD digits (seconds ones/tens, minutes ones/tens) from that stage on a load pulse.
- Counts seconds in BCD from a parameterised clock prescaler.
- Drives four BCD digits to the seven-segment display stage.

Parameters:
- CLOCK_DIVIDER, 50_000_000, clock cycles per one-second tick; legal range 2 or more. Benches use 4.

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- load  input  1  one-cycle request to capture the digit inputs
- start  input  1  one-cycle request to begin or resume counting
- stop  input  1  one-cycle request to halt counting
- digit_second_0_in  input  4  BCD seconds ones to load
- digit_second_1_in  input  4  BCD seconds tens to load
- digit_minute_0_in  input  4  BCD minutes ones to load
- digit_minute_1_in  input  4  BCD minutes tens to load
- digit_second_0  output  4  current seconds ones
- digit_second_1  output  4  current seconds tens
- digit_minute_0  output  4  current minutes ones
- digit_minute_1  output  4  current minutes tens
- running  output  1  1 while in RUNNING
- second_tick  output  1  one-cycle pulse on each one-second increment
- rollover  output  1  one-cycle pulse on the 59:59 to 00:00 wrap
- load_error  output  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset_n = 0, asynchronous):
  - All digits 0; state STOPPED; running 0.
  - Prescaler 0; second_tick, rollover and load_error all 0.
  - Takes effect immediately, including mid-count. Operation resumes on the first rising edge after reset_n returns to 1.
- All outputs are registered.
- State machine, two states:
  - STOPPED: start=1 moves to RUNNING.
  - RUNNING: stop=1 moves to STOPPED.
  - start and stop together: stop wins; result is STOPPED.
  - running = (state == RUNNING).
- Prescaler, width ceil(log2(CLOCK_DIVIDER)):
  - Held at 0 in STOPPED; cleared on stop and on an accepted load.
  - In RUNNING, increments each cycle.
  - At CLOCK_DIVIDER-1 it wraps to 0 and a tick occurs on that edge.
  - With start registered at edge k, the first tick occurs at edge k+CLOCK_DIVIDER.
- Tick (same edge, registered):
  - Digits advance one second; second_tick=1 for exactly one cycle.
- BCD increment cascade:
  - s0 9 to 0 carries into s1.
  - s1 5 to 0 carries into m0.
  - m0 9 to 0 carries into m1.
  - m1 5 to 0 wraps the whole value: 59:59 becomes 00:00 and rollover=1 in the same cycle as second_tick.
- Load validation: accepted only if s0 ≤ 9, s1 ≤ 5, m0 ≤ 9 and m1 ≤ 5.
  - Accepted load: digits take the inputs on the next edge and the prescaler clears. State is unchanged, so a load while RUNNING keeps counting from the new value.
  - Rejected load: digits and prescaler unchanged; load_error=1 for one cycle.
- Priority in one cycle: reset > load > tick.
  - A load coinciding with prescaler wrap suppresses that tick: no second_tick, no rollover, loaded value shown.
  - A rejected load does not suppress the tick.
- stop coinciding with prescaler wrap: the tick is discarded, digits unchanged, state becomes STOPPED.
- Digits never leave legal BCD ranges. Illegal values are unreachable because loads are validated.
- start while already RUNNING and stop while STOPPED: no effect.

Test Plan (CLOCK_DIVIDER=4):
1. Reset, then load 12:34 (inputs 4,3,2,1), then start.
   - Digits read 1,2,3,4 (m1..s0) one cycle after load; running=1.
   - Tick 4 cycles after start, giving 12:35.
2. Load 59:58, start, run 8 cycles.
   - 59:59 after the first tick.
   - Then 00:00, with second_tick and rollover both high for one cycle.
3. Load 09:59 and run one tick.
   - Result 10:00; no rollover.
4. Load s1=6 (e.g. 00:60), then separately load m0=10.
   - Each gives a one-cycle load_error; digits keep their prior value.
5. While running at 00:05, assert start and stop together, and stop on a wrap edge.
   - STOPPED, running=0, no tick; digits frozen at 00:05 for 20 cycles.
   - Start again: the next tick arrives exactly 4 cycles later.
6. Assert reset_n low between clock edges mid-count at 33:21.
   - All outputs 0 immediately without a clock edge; STOPPED after release.
   - Load during a wrap edge: loaded value appears with no second_tick.

Source files
------------

// File: rtl/mmss_time_counter.sv
// MM:SS real-time counter: loads validated BCD digits, counts seconds from a
// clock prescaler and presents four registered BCD digits plus status pulses.
module mmss_time_counter #(
  parameter int CLOCK_DIVIDER = 50_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] digit_second_0_in,
  input  logic [3:0] digit_second_1_in,
  input  logic [3:0] digit_minute_0_in,
  input  logic [3:0] digit_minute_1_in,
  output logic [3:0] digit_second_0,
  output logic [3:0] digit_second_1,
  output logic [3:0] digit_minute_0,
  output logic [3:0] digit_minute_1,
  output logic       running,
  output logic       second_tick,
  output logic       rollover,
  output logic       load_error
);

  localparam int PW = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(CLOCK_DIVIDER - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [PW-1:0] prescaler, prescaler_next;
  logic [3:0]  s0_next, s1_next, m0_next, m1_next;
  logic        tick_next, rollover_next, load_error_next;

  logic load_valid, load_ok, wrap, halt, tick, at_max;

  assign load_valid = (digit_second_0_in <= 4'd9) && (digit_second_1_in <= 4'd5) &&
                      (digit_minute_0_in <= 4'd9) && (digit_minute_1_in <= 4'd5);
  assign load_ok = load && load_valid;
  assign wrap    = (state == RUNNING) && (prescaler == PRE_LAST);
  assign halt    = (state == RUNNING) && stop;
  // A tick is lost when the same edge either halts the counter or loads new digits.
  assign tick    = wrap && !halt && !load_ok;
  assign at_max  = (digit_second_0 == 4'd9) && (digit_second_1 == 4'd5) &&
                   (digit_minute_0 == 4'd9) && (digit_minute_1 == 4'd5);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next      = state;
    prescaler_next  = '0;
    s0_next         = digit_second_0;
    s1_next         = digit_second_1;
    m0_next         = digit_minute_0;
    m1_next         = digit_minute_1;
    tick_next       = tick;
    rollover_next   = tick && at_max;
    load_error_next = load && !load_valid;

    case (state)
      STOPPED: if (start && !stop) state_next = RUNNING;
      RUNNING: if (stop)           state_next = STOPPED;
      default:                     state_next = STOPPED;
    endcase

    if ((state == RUNNING) && !halt && !load_ok && !wrap)
      prescaler_next = prescaler + PW'(1);

    if (load_ok) begin
      s0_next = digit_second_0_in;
      s1_next = digit_second_1_in;
      m0_next = digit_minute_0_in;
      m1_next = digit_minute_1_in;
    end else if (tick) begin
      // BCD cascade; 59:59 falls through every carry and wraps to 00:00.
      if (digit_second_0 != 4'd9) s0_next = digit_second_0 + 4'd1;
      else begin
        s0_next = 4'd0;
        if (digit_second_1 != 4'd5) s1_next = digit_second_1 + 4'd1;
        else begin
          s1_next = 4'd0;
          if (digit_minute_0 != 4'd9) m0_next = digit_minute_0 + 4'd1;
          else begin
            m0_next = 4'd0;
            m1_next = (digit_minute_1 != 4'd5) ? digit_minute_1 + 4'd1 : 4'd0;
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= STOPPED;
      prescaler      <= '0;
      digit_second_0 <= 4'd0;
      digit_second_1 <= 4'd0;
      digit_minute_0 <= 4'd0;
      digit_minute_1 <= 4'd0;
      second_tick    <= 1'b0;
      rollover       <= 1'b0;
      load_error     <= 1'b0;
    end else begin
      state          <= state_next;
      prescaler      <= prescaler_next;
      digit_second_0 <= s0_next;
      digit_second_1 <= s1_next;
      digit_minute_0 <= m0_next;
      digit_minute_1 <= m1_next;
      second_tick    <= tick_next;
      rollover       <= rollover_next;
      load_error     <= load_error_next;
    end
  end

  assign running = (state == RUNNING);

endmodule

// File: tb/tb_mmss_time_counter.sv
// Bench for mmss_time_counter: directed scenarios plus random traffic, compared
// each cycle against a seconds-count reference model.
module tb_mmss_time_counter;

  localparam int DIV = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       load, start, stop;
  logic [3:0] in_s0, in_s1, in_m0, in_m1;
  logic [3:0] digit_second_0, digit_second_1, digit_minute_0, digit_minute_1;
  logic       running, second_tick, rollover, load_error;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: time as a plain count of seconds 0..3599.
  int m_sec, m_pre;
  bit m_run, m_tick, m_roll, m_err;

  mmss_time_counter #(.CLOCK_DIVIDER(DIV)) dut (
    .clock(clock), .reset_n(reset_n),
    .load(load), .start(start), .stop(stop),
    .digit_second_0_in(in_s0), .digit_second_1_in(in_s1),
    .digit_minute_0_in(in_m0), .digit_minute_1_in(in_m1),
    .digit_second_0(digit_second_0), .digit_second_1(digit_second_1),
    .digit_minute_0(digit_minute_0), .digit_minute_1(digit_minute_1),
    .running(running), .second_tick(second_tick),
    .rollover(rollover), .load_error(load_error)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [15:0] dig_obs();
    return {digit_minute_1, digit_minute_0, digit_second_1, digit_second_0};
  endfunction

  function automatic logic [3:0] flag_obs();
    return {running, second_tick, rollover, load_error};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_errors++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_sec = 0; m_pre = 0; m_run = 0; m_tick = 0; m_roll = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit valid, ld_ok, fire;
    valid  = (in_s0 <= 9) && (in_s1 <= 5) && (in_m0 <= 9) && (in_m1 <= 5);
    ld_ok  = load && valid;
    fire   = m_run && (m_pre == DIV - 1);
    m_tick = 0;
    m_roll = 0;
    m_err  = load && !valid;
    if (m_run && stop) begin
      m_run = 0;
      m_pre = 0;
    end else if (m_run) begin
      m_pre = (ld_ok || fire) ? 0 : m_pre + 1;
      if (fire && !ld_ok) begin
        m_tick = 1;
        m_roll = (m_sec == 3599);
        m_sec  = (m_sec + 1) % 3600;
      end
    end else if (start && !stop) begin
      m_run = 1;
    end
    if (ld_ok) m_sec = int'(in_m1) * 600 + int'(in_m0) * 60 + int'(in_s1) * 10 + int'(in_s0);
  endtask

  // Runs n cycles; pulse inputs set before the call apply to the first edge only.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      model_step();
      @(negedge clock);
      check("digits", 32'(dig_obs()), 32'(bcd(m_sec)));
      check("flags", 32'(flag_obs()), 32'({m_run, m_tick, m_roll, m_err}));
      load = 0; start = 0; stop = 0;
    end
  endtask

  task automatic do_load(input logic [3:0] m1, m0, s1, s0);
    in_m1 = m1; in_m0 = m0; in_s1 = s1; in_s0 = s0;
    load  = 1;
    cyc(1);
  endtask

  initial begin
    reset_n = 0; load = 0; start = 0; stop = 0;
    in_s0 = 0; in_s1 = 0; in_m0 = 0; in_m1 = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_digits", 32'(dig_obs()), 32'h0);
    check("reset_flags", 32'(flag_obs()), 32'h0);
    #2 reset_n = 1;
    @(negedge clock);

    // 1: load 12:34 then start; first tick DIV edges after start
    do_load(4'd1, 4'd2, 4'd3, 4'd4);
    check("t1_loaded", 32'(dig_obs()), 32'h1234);
    start = 1;
    cyc(1);
    check("t1_running", 32'(running), 32'h1);
    cyc(DIV - 1);
    check("t1_no_early_tick", 32'(second_tick), 32'h0);
    cyc(1);
    check("t1_tick", 32'({dig_obs(), second_tick}), 32'({16'h1235, 1'b1}));

    // 2: 59:58 through the full wrap
    stop = 1; cyc(1);
    do_load(4'd5, 4'd9, 4'd5, 4'd8);
    start = 1; cyc(1);
    cyc(DIV);
    check("t2_5959", 32'(dig_obs()), 32'h5959);
    cyc(DIV);
    check("t2_wrap", 32'({dig_obs(), second_tick, rollover}), 32'({16'h0000, 2'b11}));
    cyc(1);
    check("t2_pulse_end", 32'({second_tick, rollover}), 32'h0);

    // 3: 09:59 -> 10:00 without rollover (load while running clears prescaler)
    do_load(4'd0, 4'd9, 4'd5, 4'd9);
    cyc(DIV);
    check("t3_carry", 32'({dig_obs(), second_tick, rollover}), 32'({16'h1000, 2'b10}));

    // 4: rejected loads
    stop = 1; cyc(1);
    do_load(4'd0, 4'd0, 4'd6, 4'd0);
    check("t4_s1_reject", 32'({dig_obs(), load_error}), 32'({16'h1000, 1'b1}));
    cyc(1);
    check("t4_err_pulse", 32'(load_error), 32'h0);
    do_load(4'd0, 4'd10, 4'd0, 4'd0);
    check("t4_m0_reject", 32'({dig_obs(), load_error}), 32'({16'h1000, 1'b1}));

    // 5: start+stop together, then stop on a wrap edge
    do_load(4'd0, 4'd0, 4'd0, 4'd4);
    start = 1; cyc(1);
    cyc(DIV);
    start = 1; stop = 1; cyc(1);
    check("t5_both", 32'({dig_obs(), running}), 32'({16'h0005, 1'b0}));
    cyc(20);
    check("t5_frozen", 32'(dig_obs()), 32'h0005);
    start = 1; cyc(1);
    cyc(DIV - 1);
    stop = 1; cyc(1);
    check("t5_stop_wrap", 32'({dig_obs(), running, second_tick}), 32'({16'h0005, 2'b00}));
    start = 1; cyc(1);
    cyc(DIV - 1);
    check("t5_restart_wait", 32'(second_tick), 32'h0);
    cyc(1);
    check("t5_restart_tick", 32'({dig_obs(), second_tick}), 32'({16'h0006, 1'b1}));

    // 6: asynchronous reset mid-count, then load on a wrap edge
    do_load(4'd3, 4'd3, 4'd2, 4'd1);
    cyc(2);
    #2 reset_n = 0;
    model_reset();
    #1;
    check("t6_async_digits", 32'(dig_obs()), 32'h0);
    check("t6_async_flags", 32'(flag_obs()), 32'h0);
    @(negedge clock);
    #2 reset_n = 1;
    @(negedge clock);
    cyc(2);
    check("t6_stopped", 32'(running), 32'h0);
    start = 1; cyc(1);
    cyc(DIV - 1);
    do_load(4'd1, 4'd2, 4'd0, 4'd0);
    check("t6_load_wrap", 32'({dig_obs(), second_tick}), 32'({16'h1200, 1'b0}));

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        load = 1;
        if ($urandom_range(0, 3) != 0) begin
          in_s0 = 4'($urandom_range(0, 9)); in_s1 = 4'($urandom_range(0, 5));
          in_m0 = 4'($urandom_range(0, 9)); in_m1 = 4'($urandom_range(0, 5));
          if ($urandom_range(0, 3) == 0) begin
            in_s0 = 4'd9; in_s1 = 4'd5; in_m0 = 4'd9; in_m1 = 4'd5;
          end
        end else begin
          in_s0 = 4'($urandom); in_s1 = 4'($urandom);
          in_m0 = 4'($urandom); in_m1 = 4'($urandom);
        end
      end
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 31) == 0);
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
